// File: rtl/step_sequencer_pkg.sv
// Shared constants and types for the trace step sequencer: step layout,
// FSM states, error codes and the architectural register bundle.
package step_sequencer_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned STEP_W         = 560;
  localparam int unsigned WORDS_PER_STEP = 18;
  localparam int unsigned WIDX_W         = 5;
  localparam int unsigned NUM_FIELDS     = 10;
  localparam int unsigned FIELD_W        = 32;
  localparam int unsigned REGS_W         = NUM_FIELDS * FIELD_W;
  localparam int unsigned CNT_W          = 32;

  // Register fields occupy step[463:144], eax at the top, eflags at the bottom.
  localparam int unsigned REGS_HI        = 463;
  localparam int unsigned REGS_LO        = 144;
  localparam int unsigned TAIL_W         = 16;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TRUNC    = 2'd2;

  typedef struct packed {
    logic [FIELD_W-1:0] eax;
    logic [FIELD_W-1:0] ebx;
    logic [FIELD_W-1:0] ecx;
    logic [FIELD_W-1:0] edx;
    logic [FIELD_W-1:0] esi;
    logic [FIELD_W-1:0] edi;
    logic [FIELD_W-1:0] esp;
    logic [FIELD_W-1:0] ebp;
    logic [FIELD_W-1:0] eip;
    logic [FIELD_W-1:0] eflags;
  } regs_t;

endpackage

// File: rtl/step_compare.sv
// Field-wise comparison of the captured post-state against the next step's
// register fields; bit i flags a masked-in mismatch on field i (0 = eax).
module step_compare
  import step_sequencer_pkg::*;
(
  input  regs_t                 exp_regs,
  input  regs_t                 step_regs,
  input  logic [NUM_FIELDS-1:0] cmp_mask,
  output logic [NUM_FIELDS-1:0] mm_c
);

  logic [REGS_W-1:0] exp_vec;
  logic [REGS_W-1:0] step_vec;

  assign exp_vec  = exp_regs;
  assign step_vec = step_regs;

  for (genvar i = 0; i < int'(NUM_FIELDS); i++) begin : g_field
    localparam int unsigned HI = REGS_W - 1 - FIELD_W * i;
    assign mm_c[i] = (exp_vec[HI -: FIELD_W] != step_vec[HI -: FIELD_W]) && cmp_mask[i];
  end

endmodule

// File: rtl/step_sequencer.sv
// Assembles trace words into steps, drives the single-step core, captures its
// post-state and verifies it against the register fields of the next step.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter logic [NUM_FIELDS-1:0] CMP_MASK = 10'h3FF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_W-1:0]     s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [STEP_W-1:0]     step_o,
  input  logic [FIELD_W-1:0]    t_eax,
  input  logic [FIELD_W-1:0]    t_ebx,
  input  logic [FIELD_W-1:0]    t_ecx,
  input  logic [FIELD_W-1:0]    t_edx,
  input  logic [FIELD_W-1:0]    t_esi,
  input  logic [FIELD_W-1:0]    t_edi,
  input  logic [FIELD_W-1:0]    t_esp,
  input  logic [FIELD_W-1:0]    t_ebp,
  input  logic [FIELD_W-1:0]    t_eip,
  input  logic [FIELD_W-1:0]    t_eflags,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            err_code,
  output logic [NUM_FIELDS-1:0] err_mask,
  output logic [CNT_W-1:0]      step_count
);

  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS_PER_STEP - 1);

  state_t                state_q, state_d;
  logic [WIDX_W-1:0]     widx_q, widx_d;
  regs_t                 exp_q, exp_d;
  logic                  have_exp_q, have_exp_d;
  logic                  last_q, last_d;
  logic                  started_q, started_d;
  logic [STEP_W-1:0]     step_d;
  logic                  s_ready_d, busy_d, done_d, pass_d;
  logic [1:0]            err_code_d;
  logic [NUM_FIELDS-1:0] err_mask_d;
  logic [CNT_W-1:0]      count_d;
  logic [NUM_FIELDS-1:0] mm_c;
  regs_t                 step_regs;
  logic                  accept;
  int unsigned           wr_hi;

  assign step_regs = step_o[REGS_HI:REGS_LO];

  step_compare u_compare (
    .exp_regs  (exp_q),
    .step_regs (step_regs),
    .cmp_mask  (CMP_MASK),
    .mm_c      (mm_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    exp_d      = exp_q;
    have_exp_d = have_exp_q;
    last_d     = last_q;
    started_d  = started_q;
    step_d     = step_o;
    pass_d     = pass;
    err_code_d = err_code;
    err_mask_d = err_mask;
    count_d    = step_count;
    accept     = s_valid && s_ready;
    wr_hi      = STEP_W - 1 - WORD_W * int'(widx_q);

    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          started_d = 1'b1;
          if (widx_q == LAST_WIDX) begin
            // Final word contributes only its low half.
            step_d[TAIL_W-1:0] = s_data[TAIL_W-1:0];
            widx_d             = '0;
            last_d             = s_last;
            state_d            = have_exp_q ? ST_CHECK : ST_CAPTURE;
          end else begin
            step_d[wr_hi -: WORD_W] = s_data;
            widx_d                  = widx_q + WIDX_W'(1);
            if (s_last) begin
              state_d    = ST_DONE;
              err_code_d = ERR_TRUNC;
              pass_d     = 1'b0;
            end
          end
        end
      end
      ST_CAPTURE: begin
        exp_d      = {t_eax, t_ebx, t_ecx, t_edx, t_esi, t_edi, t_esp, t_ebp, t_eip, t_eflags};
        have_exp_d = 1'b1;
        if (last_q) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CHECK: begin
        if (mm_c != '0) begin
          state_d    = ST_DONE;
          err_mask_d = mm_c;
          err_code_d = ERR_MISMATCH;
          pass_d     = 1'b0;
        end else begin
          if (step_count != '1) count_d = step_count + CNT_W'(1);
          state_d = ST_CAPTURE;
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
    done_d    = (state_d == ST_DONE);
    busy_d    = (state_d != ST_DONE) && started_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      widx_q     <= '0;
      exp_q      <= '0;
      have_exp_q <= 1'b0;
      last_q     <= 1'b0;
      started_q  <= 1'b0;
      step_o     <= '0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_code   <= ERR_NONE;
      err_mask   <= '0;
      step_count <= '0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      exp_q      <= exp_d;
      have_exp_q <= have_exp_d;
      last_q     <= last_d;
      started_q  <= started_d;
      step_o     <= step_d;
      s_ready    <= s_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_code   <= err_code_d;
      err_mask   <= err_mask_d;
      step_count <= count_d;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench: two sequencers (full mask and eip masked off) share one
// random trace stream; a trace-level reference model predicts each outcome.
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;

  logic         s_ready_a, busy_a, done_a, pass_a;
  logic [559:0] step_a;
  logic [1:0]   err_code_a;
  logic [9:0]   err_mask_a;
  logic [31:0]  count_a;
  logic         s_ready_b, busy_b, done_b, pass_b;
  logic [559:0] step_b;
  logic [1:0]   err_code_b;
  logic [9:0]   err_mask_b;
  logic [31:0]  count_b;
  logic [31:0]  ta [10];
  logic [31:0]  tb [10];

  int n_checks = 0;
  int n_errors = 0;

  logic [559:0] tr [$];
  int           trunc_word = -1;
  int           gap_pct = 0;
  logic [15:0]  junk = 16'h0;

  always #5 clk = ~clk;

  // Core stub: echoes the step's register fields with eax incremented.
  for (genvar i = 0; i < 10; i++) begin : g_stub
    assign ta[i] = step_a[463-32*i -: 32] + ((i == 0) ? 32'd1 : 32'd0);
    assign tb[i] = step_b[463-32*i -: 32] + ((i == 0) ? 32'd1 : 32'd0);
  end

  step_sequencer #(.CMP_MASK(10'h3FF)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_a), .step_o(step_a),
    .t_eax(ta[0]), .t_ebx(ta[1]), .t_ecx(ta[2]), .t_edx(ta[3]), .t_esi(ta[4]),
    .t_edi(ta[5]), .t_esp(ta[6]), .t_ebp(ta[7]), .t_eip(ta[8]), .t_eflags(ta[9]),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_code(err_code_a),
    .err_mask(err_mask_a), .step_count(count_a)
  );

  step_sequencer #(.CMP_MASK(10'h2FF)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_b), .step_o(step_b),
    .t_eax(tb[0]), .t_ebx(tb[1]), .t_ecx(tb[2]), .t_edx(tb[3]), .t_esi(tb[4]),
    .t_edi(tb[5]), .t_esp(tb[6]), .t_ebp(tb[7]), .t_eip(tb[8]), .t_eflags(tb[9]),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_code(err_code_b),
    .err_mask(err_mask_b), .step_count(count_b)
  );

  task automatic chk(input string tag, input logic [559:0] got, input logic [559:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [559:0] s, input int i);
    return s[463-32*i -: 32];
  endfunction

  function automatic logic [559:0] with_fld(input logic [559:0] s, input int i, input logic [31:0] v);
    logic [559:0] r = s;
    r[463-32*i -: 32] = v;
    return r;
  endfunction

  function automatic logic [559:0] rand_step();
    logic [559:0] r = '0;
    for (int k = 0; k < 18; k++) r = (r << 32) | 560'($urandom());
    return r;
  endfunction

  // Clean trace: each step's registers equal the previous post-state (eax+1).
  task automatic build_clean(input int n);
    logic [559:0] s;
    tr.delete();
    trunc_word = -1;
    tr.push_back(rand_step());
    for (int j = 1; j < n; j++) begin
      s = rand_step();
      for (int i = 0; i < 10; i++)
        s = with_fld(s, i, fld(tr[j-1], i) + ((i == 0) ? 32'd1 : 32'd0));
      tr.push_back(s);
    end
  endtask

  // Trace-level expectation: first masked mismatch wins, else truncation, else pass.
  task automatic model(input logic [9:0] mask, output logic e_pass, output logic [1:0] e_code,
                       output logic [9:0] e_mask, output logic [31:0] e_count, output int last_idx);
    int nfull = (trunc_word >= 0) ? tr.size() - 1 : tr.size();
    logic [9:0] m;
    e_pass = 1'b1; e_code = 2'd0; e_mask = '0; e_count = '0; last_idx = nfull - 1;
    for (int j = 1; j < nfull; j++) begin
      m = '0;
      for (int i = 0; i < 10; i++)
        if ((fld(tr[j-1], i) + ((i == 0) ? 32'd1 : 32'd0)) != fld(tr[j], i) && mask[i]) m[i] = 1'b1;
      if (m != 0) begin
        e_pass = 1'b0; e_code = 2'd1; e_mask = m; last_idx = j;
        return;
      end
      e_count++;
    end
    if (trunc_word >= 0) begin
      e_pass = 1'b0; e_code = 2'd2;
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  // Offers one beat (after random idle gaps) until the masked instance takes it.
  task automatic send_word(input logic [31:0] d, input logic l);
    int guard = 0;
    if (done_b) return;
    while ($urandom_range(0, 99) < gap_pct) begin
      s_valid = 1'b0; s_last = 1'($urandom()); s_data = $urandom();
      @(negedge clk);
    end
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready_b) begin
      @(negedge clk);
      guard++;
      if (done_b || guard > 40) begin
        s_valid = 1'b0; s_last = 1'b0;
        if (!done_b) chk("ready_timeout", 1'b0, 1'b1);
        return;
      end
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_step(input logic [559:0] s, input int nwords, input logic last_flag);
    logic [31:0] w;
    for (int k = 0; k < nwords; k++) begin
      w = (k < 17) ? s[559-32*k -: 32] : {junk, s[15:0]};
      send_word(w, last_flag && (k == nwords - 1));
    end
  endtask

  task automatic run_trace(input string name, input logic with_reset);
    logic ep; logic [1:0] ec; logic [9:0] em; logic [31:0] cnt; int li;
    int guard = 0;
    if (with_reset) do_reset();
    for (int j = 0; j < tr.size(); j++) begin
      if (trunc_word >= 0 && j == tr.size() - 1) send_step(tr[j], trunc_word + 1, 1'b1);
      else send_step(tr[j], 18, j == tr.size() - 1);
    end
    while (!(done_a && done_b) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk({name, ".done_a"}, done_a, 1'b1);
    chk({name, ".done_b"}, done_b, 1'b1);
    model(10'h3FF, ep, ec, em, cnt, li);
    chk({name, ".pass_a"}, pass_a, ep);
    chk({name, ".code_a"}, err_code_a, ec);
    chk({name, ".mask_a"}, err_mask_a, em);
    chk({name, ".count_a"}, count_a, cnt);
    if (ec != 2'd2 && li >= 0) chk({name, ".step_a"}, step_a, tr[li]);
    chk({name, ".ready_a"}, s_ready_a, 1'b0);
    chk({name, ".busy_a"}, busy_a, 1'b0);
    model(10'h2FF, ep, ec, em, cnt, li);
    chk({name, ".pass_b"}, pass_b, ep);
    chk({name, ".code_b"}, err_code_b, ec);
    chk({name, ".mask_b"}, err_mask_b, em);
    chk({name, ".count_b"}, count_b, cnt);
    if (ec != 2'd2 && li >= 0) chk({name, ".step_b"}, step_b, tr[li]);
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".ready"}, s_ready_a, 1'b0);
    chk({name, ".step"}, step_a, '0);
    chk({name, ".busy"}, busy_a, 1'b0);
    chk({name, ".done"}, done_a, 1'b0);
    chk({name, ".pass"}, pass_a, 1'b0);
    chk({name, ".code"}, err_code_a, 2'd0);
    chk({name, ".mask"}, err_mask_a, 10'h0);
    chk({name, ".count"}, count_a, 32'h0);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready_after", s_ready_a, 1'b1);

    // Clean three-step trace
    build_clean(3);
    run_trace("clean3", 1'b1);
    chk("clean3.count_const", count_a, 32'd2);
    chk("clean3.pass_const", pass_a, 1'b1);

    // eflags mismatch on the second transition
    build_clean(3);
    for (int j = 0; j < 2; j++) tr[j] = with_fld(tr[j], 9, 32'h246);
    tr[2] = with_fld(tr[2], 9, 32'h202);
    run_trace("eflags", 1'b1);
    chk("eflags.mask_const", err_mask_a, 10'h200);
    chk("eflags.count_const", count_a, 32'd1);

    // eip mismatch: fails with full mask, passes with eip masked off
    build_clean(3);
    tr[1] = with_fld(tr[1], 8, fld(tr[1], 8) ^ 32'h10);
    run_trace("eip", 1'b1);
    chk("eip.mask_a_const", err_mask_a, 10'h100);
    chk("eip.pass_b_const", pass_b, 1'b1);

    // Truncated second step (s_last on word 9)
    build_clean(1);
    tr.push_back(rand_step());
    trunc_word = 9;
    run_trace("trunc", 1'b1);
    chk("trunc.code_const", err_code_a, 2'd2);
    chk("trunc.count_const", count_a, 32'd0);

    // Single-step trace with junk upper half on the last word
    build_clean(1);
    junk = 16'hDEAD;
    run_trace("single", 1'b1);
    chk("single.pass_const", pass_a, 1'b1);

    // Reset pulse at word 5 of step 2, then a clean two-step trace
    build_clean(3);
    gap_pct = 30;
    do_reset();
    send_step(tr[0], 18, 1'b0);
    send_step(tr[1], 5, 1'b0);
    chk("midrst.busy_before", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    build_clean(2);
    run_trace("after_rst", 1'b0);
    chk("after_rst.count_const", count_a, 32'd1);

    // Randomized traces
    for (int t = 0; t < 20; t++) begin
      int n = $urandom_range(1, 4);
      gap_pct = $urandom_range(0, 40);
      junk = 16'($urandom());
      build_clean(n);
      if (n > 1 && $urandom_range(0, 99) < 40) begin
        int j = $urandom_range(1, n - 1);
        int i = $urandom_range(0, 9);
        logic [31:0] x = $urandom() | 32'h1;
        tr[j] = with_fld(tr[j], i, fld(tr[j], i) ^ x);
      end
      if ($urandom_range(0, 99) < 20) begin
        tr.push_back(rand_step());
        trunc_word = $urandom_range(0, 16);
      end
      run_trace($sformatf("rand%0d", t), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
